// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with register-file writeback.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero completes in 1 cycle.
// Backpressure: none; start is accepted only in IDLE, and a start while busy is dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, op             request (op 0 = multiply, 1 = divide), sampled only in IDLE
//   operand_a, operand_b  multiplicand/dividend, multiplier/divisor
//   dest                  register-file destination index for the LO result
//   abort                 cancels an in-flight MUL/DIV without touching hi/lo
//   busy, done            status; done is a one-cycle pulse with valid hi/lo
//   hi, lo, div_by_zero   held results (product hi/lo or remainder/quotient)
//   wb_en, wb_dest, wb_data  register-file write port (wb_data mirrors lo)
module mult_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       dest,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             wb_en,
    output logic [2:0]       wb_dest,
    output logic [WIDTH-1:0] wb_data
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;       // latched multiplicand
    logic [WIDTH-1:0] b_q;       // latched divisor
    logic [WIDTH-1:0] wh_q;      // working high word: partial product / partial remainder
    logic [WIDTH-1:0] wl_q;      // working low word: multiplier shifting out / dividend -> quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [2:0]       dest_q;
    logic             dbz_q;
    logic             done_q;
    logic             wb_en_q;
    logic [CW-1:0]    cnt_q;

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {carry, hi, lo} right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;

    // Divide step: shift the next dividend bit into the remainder and subtract
    // the divisor only if it fits (restoring = keep the shifted value otherwise).
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_d;
    logic [WIDTH-1:0] div_lo_d;

    logic             last_iter;

    always_comb begin
        mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_hi_d  = mul_sum[WIDTH:1];
        mul_lo_d  = {mul_sum[0], wl_q[WIDTH-1:1]};

        div_shift = {wh_q, wl_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        // The remainder is always below b, so the low WIDTH bits of the difference suffice.
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        div_hi_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo_d  = {wl_q[WIDTH-2:0], div_ge};

        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wh_q    <= '0;
            wl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dest_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                    // abort has no meaning here; start always wins.
                    if (start) begin
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        dest_q <= dest;
                        cnt_q  <= '0;
                        wh_q   <= '0;
                        if (!op) begin
                            wl_q    <= operand_b;
                            dbz_q   <= 1'b0;
                            state_q <= S_MUL;
                        end else if (operand_b != '0) begin
                            wl_q    <= operand_a;
                            dbz_q   <= 1'b0;
                            state_q <= S_DIV;
                        end else begin
                            // Divide by zero: no iterations, result straight to DONE.
                            wl_q    <= operand_a;
                            hi_q    <= operand_a;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            wb_en_q <= (dest != 3'd0);
                            state_q <= S_DONE;
                        end
                    end
                end

                S_MUL: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        wh_q  <= mul_hi_d;
                        wl_q  <= mul_lo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) begin
                            hi_q    <= mul_hi_d;
                            lo_q    <= mul_lo_d;
                            done_q  <= 1'b1;
                            wb_en_q <= (dest_q != 3'd0);
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DIV: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        wh_q  <= div_hi_d;
                        wl_q  <= div_lo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) begin
                            hi_q    <= div_hi_d;
                            lo_q    <= div_lo_d;
                            done_q  <= 1'b1;
                            wb_en_q <= (dest_q != 3'd0);
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Start is not sampled here; the next acceptance is in IDLE.
                    done_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign wb_en       = wb_en_q;
    assign wb_dest     = dest_q;
    assign wb_data     = lo_q;

endmodule
